// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Sequential signed multiply (radix-2 Booth) / divide
//               (restoring) unit, one result bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_count;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;

    logic             w_div_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_booth;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_div_zero = op && (b == '0);
    assign w_a_mag    = a[WIDTH-1] ? -a : a;
    assign w_b_mag    = b[WIDTH-1] ? -b : b;

    // Booth step on a sign-extended upper half so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        w_booth = {r_acc_hi[WIDTH-1], r_acc_hi};
        case ({r_acc_lo[0], r_qm1})
            2'b01:   w_booth = {r_acc_hi[WIDTH-1], r_acc_hi} + {r_m[WIDTH-1], r_m};
            2'b10:   w_booth = {r_acc_hi[WIDTH-1], r_acc_hi} - {r_m[WIDTH-1], r_m};
            default: w_booth = {r_acc_hi[WIDTH-1], r_acc_hi};
        endcase
    end

    // Restoring step: the partial remainder stays below the divisor, so the
    // low WIDTH bits of the difference are exact whenever the trial fits.
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_m});
    assign w_diff  = w_shift[WIDTH-1:0] - r_m;

    assign w_quot = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem  = r_neg_r ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start && !w_div_zero) w_state_next = S_RUN;
            S_RUN:    if (r_count == c_LAST) w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_op     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_div_zero) begin
                        div0 <= 1'b1;
                    end else if (start) begin
                        busy     <= 1'b1;
                        r_count  <= '0;
                        r_op     <= op;
                        r_qm1    <= 1'b0;
                        r_acc_hi <= '0;
                        r_acc_lo <= op ? w_a_mag : a;
                        r_m      <= op ? w_b_mag : b;
                        r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r  <= a[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_op) begin
                        r_acc_hi <= w_fits ? w_diff : w_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc_hi <= w_booth[WIDTH:1];
                        r_acc_lo <= {w_booth[0], r_acc_lo[WIDTH-1:1]};
                        r_qm1    <= r_acc_lo[0];
                    end
                end
                S_FINISH: begin
                    hi   <= r_op ? w_rem  : r_acc_hi;
                    lo   <= r_op ? w_quot : r_acc_lo;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model; directed corner cases plus random operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    // Signed 64-bit arithmetic; longint avoids the INT_MIN / -1 overflow.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p  = sx * sy;
            mh = p[63:32];
            ml = p[31:0];
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            mh = r[31:0];
            ml = q[31:0];
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge; start is sampled on the next rising edge.
    task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                         input logic [31:0] y, input int glitch);
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        bit          stable;
        model(o, x, y, eh, el);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        chk({tag, " busy_at_e0"}, 32'(busy), 32'd1);
        chk({tag, " done_at_e0"}, 32'(done), 32'd0);
        n = 0;
        stable = 1'b1;
        while (!done && n < 40) begin
            if (hi !== exp_hi || lo !== exp_lo || div0 !== 1'b0 || busy !== 1'b1) stable = 1'b0;
            if (n == glitch) begin
                start = 1'b1; op = 1'b0; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " hold_during_run"}, 32'(stable), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " div0_at_done"}, 32'(div0), 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        exp_hi = eh;
        exp_lo = el;
    endtask

    initial begin
        logic        ro;
        logic [31:0] rx;
        logic [31:0] ry;

        reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst div0", 32'(div0), 32'd0);
        reset = 1'b0;

        do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD, -1);
        chk("mul_7_m3 hi_const", hi, 32'hFFFFFFFF);
        chk("mul_7_m3 lo_const", lo, 32'hFFFFFFEB);
        do_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000, -1);
        chk("mul_min_min hi_const", hi, 32'h40000000);
        chk("mul_min_min lo_const", lo, 32'h00000000);
        do_op("mul_ffff", 1'b0, 32'h0000FFFF, 32'h0000FFFF, -1);
        chk("mul_ffff lo_const", lo, 32'hFFFE0001);
        do_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, -1);
        chk("div_m7_2 lo_const", lo, 32'hFFFFFFFD);
        chk("div_m7_2 hi_const", hi, 32'hFFFFFFFF);
        do_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
        chk("div_100_7 lo_const", lo, 32'd14);
        chk("div_100_7 hi_const", hi, 32'd2);

        do_op("setup_11_22", 1'b1, 32'h2211, 32'h100, -1);
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("div0 pulse", 32'(div0), 32'd1);
        chk("div0 busy", 32'(busy), 32'd0);
        chk("div0 done", 32'(done), 32'd0);
        chk("div0 hi", hi, 32'h11);
        chk("div0 lo", lo, 32'h22);
        @(negedge clk);
        chk("div0 pulse_end", 32'(div0), 32'd0);
        chk("div0 busy_after", 32'(busy), 32'd0);

        start = 1'b1; op = 1'b0; a = 32'h12345678; b = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        do_op("div_9_3", 1'b1, 32'd9, 32'd3, -1);
        chk("div_9_3 lo_const", lo, 32'd3);
        chk("div_9_3 hi_const", hi, 32'd0);

        do_op("div_ovf_glitch", 1'b1, 32'h80000000, 32'hFFFFFFFF, 4);
        chk("div_ovf lo_const", lo, 32'h80000000);
        chk("div_ovf hi_const", hi, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 15)) - 32'd8;
            if ($urandom_range(0, 5) == 0) rx = 32'h80000000;
            if (ro && ry == 32'd0) ry = 32'd1;
            do_op($sformatf("rand%0d", i), ro, rx, ry, -1);
        end

        @(negedge clk);
        chk("final done_low", 32'(done), 32'd0);
        chk("final busy_low", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
